uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter (strobe/busy interface: `wr`, `tx_data`, `busy`) among N client streams.
- Round-robin arbitration with packet lock: a granted client keeps the transmitter until it sends a byte flagged `last`, or until it stalls past a timeout.
- Sits between the console/debug sources and the `buart` transmit side.
- Sequences the strobe so that no write is ever issued while the transmitter is busy, including the window before `busy` asserts.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- IW, $clog2(N), width of `grant_id`.
- TIMEOUT, 1023, idle cycles of the owner before its lock is forcibly released; legal range 1..65535.
- TW, $clog2(TIMEOUT+1), width of the stall counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  N  client i has a byte on `req_data[8i+7:8i]`.
- req_data  in  8*N  per-client byte, packed.
- req_last  in  N  the byte offered by client i ends its packet.
- req_ready  out  N  one-cycle accept pulse to client i (combinational from state and inputs).
- tx_wr  out  1  write strobe to the transmitter (registered).
- tx_data  out  8  byte to the transmitter (registered, valid when `tx_wr`=1).
- tx_busy  in  1  transmitter busy.
- grant_active  out  1  a client holds the lock (registered).
- grant_id  out  IW  index of the lock holder (registered; meaningful only while `grant_active`).

Behaviour:
- Reset values: `tx_wr`=0, `tx_data`=0, `grant_active`=0, `grant_id`=0, rr pointer=N-1, holdoff=0, stall counter=0. `req_ready`=0 during reset.
- Reset mid-byte: any pending strobe is dropped. A byte already accepted but not yet strobed is lost. The transmitter is not otherwise affected.
- States: IDLE, LOCKED.
- IDLE:
  - If any `req_valid` is set: grant the first set bit searching `ptr+1`, `ptr+2`, … modulo N.
  - Set `grant_id`, set `grant_active`=1, clear the stall counter, go to LOCKED.
  - The grant cycle never accepts a byte; the earliest accept is the following cycle.
- LOCKED, owner o:
  - `can_send` = `req_valid[o]` & !`tx_busy` & (holdoff==0).
  - `req_ready[o]` = `can_send`; `req_ready` is 0 for every other client.
  - On accept (cycle t):
    - `tx_data` <= `req_data[o]` and `tx_wr` <= 1, so both are visible in cycle t+1.
    - `tx_wr` returns to 0 in cycle t+2; it is always a single-cycle pulse.
    - holdoff <= 2. This blocks accepts in cycles t+1 and t+2, covering the transmitter's busy-assertion latency.
  - holdoff decrements by 1 each cycle while nonzero.
  - On accept with `req_last[o]`=1:
    - `grant_active` <= 0, ptr <= o, go to IDLE.
    - The next grant may occur in cycle t+1, but its first accept is still subject to the holdoff and `tx_busy`.
  - Stall counter:
    - Increments each cycle the owner has `req_valid[o]`=0.
    - Clears on any cycle the owner has `req_valid[o]`=1.
    - When it reaches TIMEOUT: release the lock (`grant_active` <= 0, ptr <= o, go to IDLE). No byte is accepted in that cycle.
    - A `req_valid[o]` that rises in the same cycle the counter reaches TIMEOUT: the valid wins and the counter clears.
  - While the owner is stalled, other clients wait; the lock is not preempted before the timeout.
- Fairness: after client o releases, o has lowest priority at the next IDLE grant. With all clients continuously valid and every byte `last`, grants rotate 0,1,…,N-1,0,…
- No combinational path from `tx_busy` to `tx_wr`. The `tx_busy`→`req_ready` path is combinational.
- Widths:
  - Stall counter is TW bits and saturates at TIMEOUT; it never wraps.
  - holdoff is 2 bits.
  - The rr pointer wraps from N-1 to 0.

Test Plan:
- Single client 0 sends 0x41 (not last), then 0x42 (last); `tx_busy` modelled as rising 1 cycle after `tx_wr` and lasting 10 cycles:
  - grant in cycle 1; accept 0x41 in cycle 2; `tx_wr`=1 with `tx_data`=0x41 in cycle 3.
  - 0x42 is accepted only in the first cycle after `tx_busy` falls, then `grant_active` drops.
- Clients 1 and 3 both valid from reset release, single-byte packets, all `last` (ptr=3 after reset):
  - grant order is 0→skip, 1, then 3, then 1, then 3.
  - `tx_wr` never asserts while `tx_busy`=1.
- Client 2 holds the lock with a 3-byte packet while client 0 is valid: client 0 receives no `req_ready` until client 2's `last` byte; client 0 is granted next.
- TIMEOUT=8; client 1 sends 1 non-last byte then drops valid:
  - lock releases exactly 8 cycles after valid falls;
  - client 2, pending throughout, is granted the next cycle.
- Back-to-back hazard with `tx_busy` held 0 by the bench: accepted bytes are spaced exactly 3 cycles apart (holdoff), and `tx_wr` pulses are one cycle each.
- Assert `reset` for 1 cycle in the cycle after an accept:
  - `tx_wr` stays 0;
  - `grant_active`=0 and `grant_id`=0 next cycle;
  - arbitration restarts from client 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one byte UART transmitter.
// Write strobes are spaced by a holdoff so busy latency never gets overrun.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int IW      = $clog2(N),
  parameter int TIMEOUT = 1023,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  input  logic [8*N-1:0]  req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic            tx_wr,
  output logic [7:0]      tx_data,
  input  logic            tx_busy,
  output logic            grant_active,
  output logic [IW-1:0]   grant_id
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [TW-1:0] stall_q, stall_d;
  logic [1:0]    hold_q, hold_d;
  logic          wr_q, wr_d;
  logic [7:0]    dat_q, dat_d;

  logic          own_valid;
  logic          own_last;
  logic [7:0]    own_data;
  logic [IW-1:0] pick;
  logic          can_send;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (gid_q == IW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*8 +: 8];
      end
    end
  end

  // smallest rotation distance from ptr wins; ptr itself is last
  always_comb begin
    pick = ptr_q;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && i == (int'(ptr_q) + k) % N)
          pick = IW'(i);
      end
    end
  end

  assign can_send = (state_q == LOCKED) && own_valid &&
                    !tx_busy && (hold_q == 2'd0);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = can_send && !reset && (gid_q == IW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    hold_d  = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    wr_d    = 1'b0;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gid_d   = pick;
          stall_d = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (own_valid) begin
          stall_d = '0;
        end else if (stall_q == TW'(TIMEOUT)) begin
          state_d = IDLE;
          ptr_d   = gid_q;
        end else begin
          stall_d = stall_q + TW'(1);
        end
        if (can_send) begin
          wr_d   = 1'b1;
          dat_d  = own_data;
          hold_d = 2'd2;
          if (own_last) begin
            state_d = IDLE;
            ptr_d   = gid_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= IW'(N - 1);
      stall_q <= '0;
      hold_q  <= 2'd0;
      wr_q    <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
      dat_q   <= dat_d;
    end
  end

  // a strobe pending when reset arrives is dropped, not delivered
  assign tx_wr        = wr_q & ~reset;
  assign tx_data      = dat_q;
  assign grant_active = (state_q == LOCKED);
  assign grant_id     = gid_q;

endmodule
